// File: rtl/pipelined_fp_summator_if.sv
// Operand/result stream bundle for the pipelined FP summator.
// The slave modport is the summator's view; the master modport is the producer/consumer view.
interface pipelined_fp_summator_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
);
  localparam int W = 1 + EXP_W + MANT_W;

  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         sub_i;
  logic         vld_i;
  logic         rdy_o;
  logic [W-1:0] answer_o;
  logic [1:0]   status_o;
  logic         vld_o;
  logic         rdy_i;

  modport master (
    output a_i, b_i, sub_i, vld_i, rdy_i,
    input  rdy_o, answer_o, status_o, vld_o
  );

  modport slave (
    input  a_i, b_i, sub_i, vld_i, rdy_i,
    output rdy_o, answer_o, status_o, vld_o
  );
endinterface

// File: rtl/pipelined_fp_summator.sv
// Three-stage floating-point adder/subtractor with round-to-nearest-even,
// special-value handling and a status code; one global stall enable.
module pipelined_fp_summator #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pipelined_fp_summator_if.slave bus
);
  localparam int W  = 1 + EXP_W + MANT_W;
  localparam int AW = MANT_W + 4;
  localparam int SW = MANT_W + 5;
  localparam int XW = EXP_W + 2;

  function automatic logic [XW-1:0] lzc(input logic [AW-1:0] v);
    logic [XW-1:0] cnt;
    cnt = XW'(AW);
    for (int i = 0; i < AW; i++)
      if (v[i]) cnt = XW'(AW - 1 - i);
    return cnt;
  endfunction

  function automatic logic [MANT_W+1:0] rne(input logic [AW-1:0] n);
    logic up;
    up = n[2] & (n[1] | n[0] | n[3]);
    return {1'b0, n[AW-1:3]} + (MANT_W+2)'(up);
  endfunction

  logic w_en;
  assign w_en      = bus.rdy_i | ~bus.vld_o;
  assign bus.rdy_o = w_en;

  logic [W-1:0]              w_a, w_b;
  logic                      w_sa, w_sb;
  logic [EXP_W-1:0]          w_ea, w_eb, w_ex, w_ey, w_diff;
  logic [MANT_W-1:0]         w_ma, w_mb;
  logic                      w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap;
  logic [EXP_W+MANT_W-1:0]   w_mag_a, w_mag_b, w_mag_x, w_mag_y;
  logic                      w_sx, w_sy;
  logic [AW-1:0]             w_mx_ext, w_y_ext, w_my_al;
  logic [31:0]               w_shamt;
  logic [2*AW-1:0]           w_shw;

  assign w_a = bus.a_i;
  assign w_b = bus.b_i;
  assign {w_sa, w_ea, w_ma} = w_a;
  assign w_sb = w_b[W-1] ^ bus.sub_i;
  assign w_eb = w_b[W-2:MANT_W];
  assign w_mb = w_b[MANT_W-1:0];

  assign w_a_nan = (&w_ea) & (|w_ma);
  assign w_b_nan = (&w_eb) & (|w_mb);
  assign w_a_inf = (&w_ea) & ~(|w_ma);
  assign w_b_inf = (&w_eb) & ~(|w_mb);
  // Subnormals collapse to zero magnitude so they sort and align as zero.
  assign w_mag_a = (w_ea == '0) ? '0 : {w_ea, w_ma};
  assign w_mag_b = (w_eb == '0) ? '0 : {w_eb, w_mb};
  assign w_swap  = w_mag_b > w_mag_a;
  assign w_mag_x = w_swap ? w_mag_b : w_mag_a;
  assign w_mag_y = w_swap ? w_mag_a : w_mag_b;
  assign w_sx    = w_swap ? w_sb : w_sa;
  assign w_sy    = w_swap ? w_sa : w_sb;
  assign w_ex    = w_mag_x[EXP_W+MANT_W-1:MANT_W];
  assign w_ey    = w_mag_y[EXP_W+MANT_W-1:MANT_W];
  assign w_mx_ext = {|w_ex, w_mag_x[MANT_W-1:0], 3'b000};
  assign w_y_ext  = {|w_ey, w_mag_y[MANT_W-1:0], 3'b000};
  assign w_diff   = w_ex - w_ey;
  assign w_shamt  = (32'(w_diff) > 32'(AW)) ? 32'(AW) : 32'(w_diff);
  assign w_shw    = {w_y_ext, {AW{1'b0}}} >> w_shamt;
  assign w_my_al  = {w_shw[2*AW-1:AW+1], w_shw[AW] | (|w_shw[AW-1:0])};

  // ---- stage 1 -> 2 boundary: aligned operands ----
  logic              r_vld_p1, r_sx_p1, r_sub_p1, r_zs_p1;
  logic              r_nan_p1, r_inf_p1, r_infs_p1;
  logic [EXP_W-1:0]  r_ex_p1;
  logic [AW-1:0]     r_mx_p1, r_my_p1;

  always_ff @(posedge clk_i) begin
    if (w_en) begin
      r_sx_p1   <= w_sx;
      r_sub_p1  <= w_sx ^ w_sy;
      r_zs_p1   <= w_sx & w_sy;
      r_ex_p1   <= w_ex;
      r_mx_p1   <= w_mx_ext;
      r_my_p1   <= w_my_al;
      r_nan_p1  <= w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa ^ w_sb));
      r_inf_p1  <= w_a_inf | w_b_inf;
      r_infs_p1 <= w_a_inf ? w_sa : w_sb;
    end
  end

  logic [SW-1:0] w_sum;
  assign w_sum = r_sub_p1 ? ({1'b0, r_mx_p1} - {1'b0, r_my_p1})
                          : ({1'b0, r_mx_p1} + {1'b0, r_my_p1});

  // ---- stage 2 -> 3 boundary: raw sum ----
  logic              r_vld_p2, r_s_p2, r_nan_p2, r_inf_p2, r_infs_p2;
  logic [EXP_W-1:0]  r_ex_p2;
  logic [SW-1:0]     r_sum_p2;

  always_ff @(posedge clk_i) begin
    if (w_en) begin
      r_sum_p2  <= w_sum;
      r_s_p2    <= (w_sum == '0) ? r_zs_p1 : r_sx_p1;
      r_ex_p2   <= r_ex_p1;
      r_nan_p2  <= r_nan_p1;
      r_inf_p2  <= r_inf_p1;
      r_infs_p2 <= r_infs_p1;
    end
  end

  logic [XW-1:0]        w_lz;
  logic [AW-1:0]        w_norm;
  logic signed [XW-1:0] w_exp_n, w_exp_r;
  logic [MANT_W+1:0]    w_rnd;
  logic [MANT_W-1:0]    w_frac;
  logic [W-1:0]         w_ans;
  logic [1:0]           w_st;

  always_comb begin
    w_lz = '0;
    if (r_sum_p2[SW-1]) begin
      w_norm  = {r_sum_p2[SW-1:2], r_sum_p2[1] | r_sum_p2[0]};
      w_exp_n = $signed({2'b00, r_ex_p2}) + $signed(XW'(1));
    end else begin
      w_lz    = lzc(r_sum_p2[AW-1:0]);
      w_norm  = r_sum_p2[AW-1:0] << w_lz;
      w_exp_n = $signed({2'b00, r_ex_p2}) - $signed(w_lz);
    end
    w_rnd = rne(w_norm);
    if (w_rnd[MANT_W+1]) begin
      w_exp_r = w_exp_n + $signed(XW'(1));
      w_frac  = w_rnd[MANT_W:1];
    end else begin
      w_exp_r = w_exp_n;
      w_frac  = w_rnd[MANT_W-1:0];
    end

    w_ans = {r_s_p2, w_exp_r[EXP_W-1:0], w_frac};
    w_st  = 2'b00;
    if (r_nan_p2) begin
      w_ans = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
      w_st  = 2'b10;
    end else if (r_inf_p2) begin
      w_ans = {r_infs_p2, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (r_sum_p2 == '0) begin
      w_ans = {r_s_p2, {(EXP_W+MANT_W){1'b0}}};
    end else if (!w_exp_r[XW-1] && (w_exp_r[XW-2:0] >= {1'b0, {EXP_W{1'b1}}})) begin
      w_ans = {r_s_p2, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      w_st  = 2'b01;
    end else if (w_exp_r[XW-1] || (w_exp_r == '0)) begin
      w_ans = {r_s_p2, {(EXP_W+MANT_W){1'b0}}};
      w_st  = 2'b11;
    end
  end

  // ---- stage 3 output boundary: packed result ----
  logic [W-1:0] r_answer;
  logic [1:0]   r_status;
  logic         r_vld_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_o  <= 1'b0;
      r_answer <= '0;
      r_status <= '0;
    end else if (w_en) begin
      r_vld_p1 <= bus.vld_i;
      r_vld_p2 <= r_vld_p1;
      r_vld_o  <= r_vld_p2;
      r_answer <= w_ans;
      r_status <= w_st;
    end
  end

  assign bus.answer_o = r_answer;
  assign bus.status_o = r_status;
  assign bus.vld_o    = r_vld_o;
endmodule

// File: tb/tb_pipelined_fp_summator.sv
// Scoreboard bench for the pipelined FP summator: single- and double-precision
// instances, rounding/special cases, backpressure and mid-flight reset.
module tb_pipelined_fp_summator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_fp_summator_if #(.EXP_W(8),  .MANT_W(23)) if32 ();
  pipelined_fp_summator_if #(.EXP_W(11), .MANT_W(52)) if64 ();

  pipelined_fp_summator #(.EXP_W(8),  .MANT_W(23)) u32 (.clk_i(clk), .rst_i(rst), .bus(if32));
  pipelined_fp_summator #(.EXP_W(11), .MANT_W(52)) u64 (.clk_i(clk), .rst_i(rst), .bus(if64));

  int n_cmp = 0;
  int n_err = 0;
  logic [65:0] q32[$];
  logic [65:0] q64[$];

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] ea, input logic [1:0] es);
    int n = 0;
    if32.a_i = a; if32.b_i = b; if32.sub_i = s; if32.vld_i = 1'b1;
    while (!if32.rdy_o && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("rdy_timeout32", 66'(if32.rdy_o), 66'(1));
    q32.push_back({es, 32'b0, ea});
    @(negedge clk);
  endtask

  task automatic send64(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic [63:0] ea, input logic [1:0] es);
    int n = 0;
    if64.a_i = a; if64.b_i = b; if64.sub_i = s; if64.vld_i = 1'b1;
    while (!if64.rdy_o && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("rdy_timeout64", 66'(if64.rdy_o), 66'(1));
    q64.push_back({es, ea});
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 200) begin @(negedge clk); n++; end
    chk("drain", 66'(q32.size() + q64.size()), 66'(0));
  endtask

  logic        prev_stall = 1'b0;
  logic [31:0] prev_ans;
  always @(negedge clk) begin
    logic [65:0] e;
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("stall_vld", 66'(if32.vld_o), 66'(1));
        chk("stall_ans", 66'(if32.answer_o), 66'(prev_ans));
      end
      if (if32.vld_o && !if32.rdy_i) chk("stall_rdy", 66'(if32.rdy_o), 66'(0));
      if (if32.vld_o && if32.rdy_i) begin
        chk("q32_nonempty", 66'(q32.size() != 0), 66'(1));
        if (q32.size() != 0) begin
          e = q32.pop_front();
          chk("res32", {if32.status_o, 32'b0, if32.answer_o}, e);
        end
      end
      prev_stall = if32.vld_o && !if32.rdy_i;
      prev_ans   = if32.answer_o;
    end
  end

  always @(negedge clk) begin
    logic [65:0] e;
    if (!rst && if64.vld_o && if64.rdy_i) begin
      chk("q64_nonempty", 66'(q64.size() != 0), 66'(1));
      if (q64.size() != 0) begin
        e = q64.pop_front();
        chk("res64", {if64.status_o, if64.answer_o}, e);
      end
    end
  end

  localparam logic [31:0] ONE = 32'h3F800000;
  logic [31:0] kin[8]  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] kout[8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                           32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

  initial begin
    if32.a_i = '0; if32.b_i = '0; if32.sub_i = 1'b0; if32.vld_i = 1'b0; if32.rdy_i = 1'b1;
    if64.a_i = '0; if64.b_i = '0; if64.sub_i = 1'b0; if64.vld_i = 1'b0; if64.rdy_i = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_vld32", 66'(if32.vld_o), 66'(0));
    chk("rst_ans32", 66'(if32.answer_o), 66'(0));
    chk("rst_st32",  66'(if32.status_o), 66'(0));
    chk("rst_rdy32", 66'(if32.rdy_o), 66'(1));
    chk("rst_vld64", 66'(if64.vld_o), 66'(0));

    send32(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 2'b00);
    send32(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 2'b00);
    send32(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 2'b00);
    send32(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 2'b00);
    send32(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 2'b00);
    send32(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 2'b00);
    send32(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 2'b10);
    send32(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 2'b01);
    send32(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 2'b11);
    send32(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 2'b10);
    send32(32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 2'b00);
    if32.vld_i = 1'b0;

    send64(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'h4008000000000000, 2'b00);
    send64(64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, 64'h3FF0000000000000, 2'b00);
    send64(64'h3FF0000000000000, 64'h3CA8000000000000, 1'b0, 64'h3FF0000000000001, 2'b00);
    if64.vld_i = 1'b0;
    drain();

    fork
      begin
        for (int k = 0; k < 8; k++) send32(kin[k], ONE, 1'b0, kout[k], 2'b00);
        if32.vld_i = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #2 if32.rdy_i = 1'b0;
        repeat (4) @(posedge clk);
        #2 if32.rdy_i = 1'b1;
      end
    join
    drain();

    @(posedge clk);
    #2 if32.rdy_i = 1'b0;
    @(negedge clk);
    send32(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 2'b00);
    send32(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 2'b00);
    send32(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 2'b00);
    if32.vld_i = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    q32.delete();
    q64.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("midrst_vld", 66'(if32.vld_o), 66'(0));
    chk("midrst_rdy", 66'(if32.rdy_o), 66'(1));
    @(posedge clk);
    #2 if32.rdy_i = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_quiet", 66'(if32.vld_o), 66'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipelined_fp_summator.md
Name: pipelined_fp_summator

Overview:
- Parametrised, 3-stage pipelined floating-point adder/subtractor; successor to the combinational single-precision summator.
- Generic exponent/mantissa widths and a per-transaction add/sub mode.
- IEEE-style round-to-nearest-even, full special-value handling and a status code.
- Valid/ready stream on both sides; sits between operand fetch and the result writeback of the FP datapath.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MANT_W, 23, stored fraction width (hidden bit implicit)
W, 1+EXP_W+MANT_W, total operand width (derived, not overridable)

Ports:
clk_i  input  1  clock
rst_i  input  1  reset: synchronous, active-high
a_i  input  W  operand A {sign, exp, mant}
b_i  input  W  operand B {sign, exp, mant}
sub_i  input  1  0: A+B, 1: A-B (B sign inverted in stage 1)
vld_i  input  1  input transaction valid
rdy_o  output  1  pipeline can accept input this cycle
answer_o  output  W  result
status_o  output  2  00 OK, 01 overflow to Inf, 10 NaN, 11 underflow flushed to zero
vld_o  output  1  answer_o/status_o valid
rdy_i  input  1  downstream accepts result

Behaviour:
- Reset (rst_i high at a clock edge): all stage valid bits, vld_o, answer_o and status_o clear to 0. Reset mid-transaction discards every in-flight result; rdy_o = 1 in the first cycle after reset.
- Flow control: global enable en = rdy_i | ~vld_o; rdy_o = en (combinational).
  - When en = 1, all stages advance one step; an input is captured when vld_i & rdy_o.
  - When en = 0, every stage holds and answer_o/status_o stay stable.
  - Bubbles travel with the pipeline and are not collapsed.
- Latency: exactly 3 enabled cycles from input capture to vld_o. Throughput: 1 per cycle while rdy_i = 1. Results emerge in order.
- Stage 1, unpack/align:
  - Apply sub_i to B's sign.
  - Subnormal inputs (exp = 0) are treated as signed zero.
  - Classify NaN (exp all-ones, mant != 0) and Inf (exp all-ones, mant = 0).
  - Swap so the larger-magnitude operand (exp, then mant) is X.
  - Right-shift Y's {1,mant} by the exponent difference into MANT_W+4 bits (guard, round, sticky); sticky ORs all shifted-out bits.
  - A difference >= MANT_W+3 leaves Y = sticky only.
- Stage 2, add/sub:
  - Effective add when signs match, else X - Y; width MANT_W+5 to hold the carry.
  - Result sign = X sign.
  - An exact zero result gets sign +, except (-0)+(-0) = -0.
- Stage 3, normalise/round/pack:
  - Carry-out: shift right 1 with sticky preserved; exponent + 1.
  - Otherwise shift left by the leading-zero count (priority encoder) and decrease the exponent.
  - Round to nearest, ties to even, on G/R/S; a mantissa carry from rounding increments the exponent again.
- Special cases, in priority order:
  - Any NaN input, or Inf - Inf: output quiet NaN {0, all-ones exp, MSB of mant = 1, rest 0}, status 10.
  - Otherwise either input Inf: output that signed Inf, status 00.
  - Finite result whose exponent reaches all-ones: signed Inf, status 01.
  - Result exponent <= 0: signed zero, status 11.
- Both operands zero gives zero with the sign rule above, status 00.

Test Plan:
- Defaults. 0x3F800000 + 0x40000000, sub_i = 0 -> after 3 cycles answer_o = 0x40400000, status 00.
- Defaults. 0x3F800000 with sub_i = 1, B = 0x3F800000 -> 0x00000000 (+0), status 00. Then 0x80000000 + 0x80000000 -> 0x80000000.
- Rounding.
  - 0x3F800000 + 0x33800000 (exact tie) -> 0x3F800000.
  - 0x3F800000 + 0x33C00000 -> 0x3F800001.
  - 0x3F800000 - 0x33800000 -> 0x3F7FFFFF.
- Specials.
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000, status 10.
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, status 01.
  - 0x00800000 - 0x00800001 -> 0x80000000, status 11.
- Backpressure.
  - Stream 8 back-to-back adds (k.0 + 1.0, k = 1..8); hold rdy_i = 0 for 4 cycles mid-stream.
  - Required: answer_o/vld_o stable while stalled, rdy_o = 0 while vld_o = 1, all 8 results in order, no loss or duplication.
- Reset and parameters.
  - Assert rst_i while 3 transactions are in flight -> vld_o = 0 next cycle and none of the 3 results ever appear.
  - Rerun the first and third scenarios with EXP_W = 11, MANT_W = 52: 1.0 + 2.0 = 0x4008000000000000, and the tie case rounds to even.
